dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Multi-cycle data-memory responder: the target end of the load/store request that the EX/MEM pipeline register issues (read enable, write enable, address, store data).
- Accepts one word-wide read or write at a time and completes it after a fixed, parameterised latency.
- Drives a stall line back to the pipeline while a transaction is in flight.
- Returns load data with a one-cycle acknowledge, for the MEM/WB register to capture.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words stored; power of two, minimum 2.
- LATENCY, 2, cycles from the acceptance edge to the completion edge; integer, minimum 1.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_en  in  1  load request; held by the initiator while stall is high.
- wr_en  in  1  store request; held by the initiator while stall is high.
- addr  in  32  byte address; word index is addr[2 +: log2(DEPTH_WORDS)].
- wdata  in  32  store data; held with wr_en.
- rdata  out  32  load data; valid while ack is high, holds its value afterwards.
- ack  out  1  one-cycle completion pulse, for both loads and stores.
- err  out  1  one-cycle error flag, coincident with ack.
- stall  out  1  pipeline must not advance while high.

Behaviour:
- Reset (async, takes effect immediately): state=IDLE, counter=0, rdata=0, ack=0, err=0. Latched request registers are cleared. Memory array is not reset; it is zero-initialised at time 0 in simulation only.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req = rd_en | wr_en.
  - stall = req, combinational, so the pipeline freezes in the same cycle the request appears.
  - On a rising edge with req=1: latch op, addr, wdata; load counter=LATENCY; go to WAIT.
- WAIT:
  - stall=1.
  - Each edge decrements counter. Inputs are ignored; the latched copy is used.
  - At the edge where counter goes 1->0: perform the access and go to RESP.
    - Read: rdata <= mem[index].
    - Write: mem[index] <= wdata_latched.
- RESP:
  - stall=0, ack=1.
  - err=1 if the latched request was erroneous.
  - Requests present in this cycle belong to the completing instruction and are not re-accepted.
  - Next edge: go to IDLE unconditionally.
- Timing: acceptance at edge k; ack high in the cycle after edge k+LATENCY. Stall is high from the first request cycle through edge k+LATENCY.
- Back-to-back requests: RESP -> IDLE -> accept. Minimum spacing between acks is LATENCY+2 cycles.
- Error cases (no memory access; rdata forced to 0 in RESP; ack and err both pulse):
  - Misaligned address: addr[1:0] != 0.
  - rd_en and wr_en both high.
- Address bits above the index field are ignored, so out-of-range addresses wrap modulo DEPTH_WORDS.
- rdata changes only on a successful read completion, an error completion (forced to 0), or reset. A write leaves rdata unchanged.
- Reset asserted mid-transaction (WAIT):
  - Transaction is abandoned; no write occurs unless the completion edge had already passed.
  - No ack is produced after reset deasserts.
  - The FSM restarts in IDLE. If a request is still present, it is accepted afresh at the first edge after rst falls.
- Read of a word written by the immediately preceding transaction returns the new data (no read-during-write hazard, since accesses are serialised).

Test Plan:
- Reset: rst=1 for 3 cycles with random inputs -> rdata=0, ack=0, err=0, stall=0 while no request; after release with rd_en=0, wr_en=0, outputs stay 0.
- Store then load, LATENCY=2:
  - wr_en, addr=0x10, wdata=0xDEADBEEF -> stall high 3 cycles, ack for 1 cycle, err=0, rdata unchanged.
  - Then rd_en, addr=0x10 -> ack with rdata=0xDEADBEEF.
- Wrap-around, DEPTH_WORDS=64: write 0xA5A5A5A5 to addr=0x100 -> read at addr=0x0 returns 0xA5A5A5A5.
- Errors:
  - rd_en, addr=0x13 -> ack=1, err=1, rdata=0.
  - rd_en=wr_en=1, addr=0x20, wdata=0x1 -> ack=1, err=1, and a later read of 0x20 returns its previous value.
- Reset mid-op: wr_en, addr=0x8, wdata=0x12345678; assert rst one cycle after acceptance (LATENCY=3) -> no ack; a subsequent read of 0x8 returns the pre-test value.
- Back-to-back, LATENCY=1: two loads held continuously (addr 0x0 then 0x4) -> acks exactly 3 cycles apart; each request is serviced exactly once, confirmed by counting acks = 2.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data-memory target for the EX/MEM load/store request, with stall and ack/err.
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        stall
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY + 1);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic          r_wr, r_err;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_wdata, r_rdata;
  logic [31:0]   r_mem [DEPTH_WORDS];
  logic          w_req, w_done, w_unused;
  assign w_req    = rd_en | wr_en;
  assign w_done   = r_state == S_WAIT && r_cnt == CW'(1);
  assign rdata    = r_rdata;
  assign w_unused = ^{addr[31:2+AW]};
  always_comb begin
    w_next = r_state == S_IDLE ? (w_req ? S_WAIT : S_IDLE) :
             r_state == S_WAIT ? (w_done ? S_RESP : S_WAIT) : S_IDLE;
    stall  = r_state == S_IDLE ? w_req : r_state == S_WAIT;
    ack    = r_state == S_RESP;
    err    = ack & r_err;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_IDLE;
    else r_state <= w_next;
  // request is latched at acceptance so the initiator's held inputs are ignored while waiting
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cnt   <= '0;
      r_wr    <= 1'b0;
      r_err   <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (r_state == S_IDLE && w_req) begin
        r_cnt   <= CW'(LATENCY);
        r_wr    <= wr_en;
        r_err   <= addr[1:0] != 2'b00 || (rd_en && wr_en);
        r_idx   <= addr[2 +: AW];
        r_wdata <= wdata;
      end else if (r_state == S_WAIT) r_cnt <= r_cnt - CW'(1);
      if (w_done && (r_err || !r_wr)) r_rdata <= r_err ? 32'h0 : r_mem[r_idx];
    end
  always_ff @(posedge clk)
    if (w_done && r_wr && !r_err) r_mem[r_idx] <= r_wdata;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks on three responders (LATENCY 2, 3 and 1).
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rsts [3];
  logic        rd [3], wr [3];
  logic [31:0] ad [3], wd [3];
  logic [31:0] rdat [3];
  logic        acks [3], errs [3], stls [3];
  int          n_vec = 0, n_bad = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) u0 (.clk(clk), .rst(rsts[0]), .rd_en(rd[0]), .wr_en(wr[0]),
    .addr(ad[0]), .wdata(wd[0]), .rdata(rdat[0]), .ack(acks[0]), .err(errs[0]), .stall(stls[0]));
  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(3)) u1 (.clk(clk), .rst(rsts[1]), .rd_en(rd[1]), .wr_en(wr[1]),
    .addr(ad[1]), .wdata(wd[1]), .rdata(rdat[1]), .ack(acks[1]), .err(errs[1]), .stall(stls[1]));
  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(1)) u2 (.clk(clk), .rst(rsts[2]), .rd_en(rd[2]), .wr_en(wr[2]),
    .addr(ad[2]), .wdata(wd[2]), .rdata(rdat[2]), .ack(acks[2]), .err(errs[2]), .stall(stls[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // drive one request, hold it until ack, drop it in the ack cycle
  task automatic op(input int s, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                    output logic [31:0] q, output logic e, output int stalls);
    bit got = 0;
    stalls = 0;
    q = 'x;
    e = 1'bx;
    @(negedge clk);
    rd[s] = r; wr[s] = w; ad[s] = a; wd[s] = d;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (acks[s]) begin
        got = 1;
        q = rdat[s];
        e = errs[s];
        rd[s] = 0; wr[s] = 0;
      end else begin
        if (stls[s]) stalls++;
        @(negedge clk);
      end
    end
    chk("ack_seen", 32'(got), 32'd1);
    rd[s] = 0; wr[s] = 0;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] q;
    logic        e;
    int          st, nack, c1, c2;
    logic [31:0] q1, q2;
    for (int s = 0; s < 3; s++) begin
      rsts[s] = 1; rd[s] = 0; wr[s] = 0; ad[s] = 0; wd[s] = 0;
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      rd[0] = 1'($urandom); wr[0] = 1'($urandom); ad[0] = $urandom; wd[0] = $urandom;
      #1;
      chk("rst_rdata", rdat[0], 32'h0);
      chk("rst_ack", 32'(acks[0]), 32'd0);
      chk("rst_err", 32'(errs[0]), 32'd0);
      chk("rst_stall", 32'(stls[0]), 32'(rd[0] | wr[0]));
    end
    @(negedge clk);
    rd[0] = 0; wr[0] = 0;
    for (int s = 0; s < 3; s++) rsts[s] = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("idle_rdata", rdat[0], 32'h0);
    chk("idle_ack", 32'(acks[0]), 32'd0);
    chk("idle_err", 32'(errs[0]), 32'd0);
    chk("idle_stall", 32'(stls[0]), 32'd0);

    op(0, 0, 1, 32'h10, 32'hDEADBEEF, q, e, st);
    chk("st_stalls", 32'(st), 32'd3);
    chk("st_err", 32'(e), 32'd0);
    chk("st_rdata_kept", q, 32'h0);
    op(0, 1, 0, 32'h10, 32'h0, q, e, st);
    chk("ld_rdata", q, 32'hDEADBEEF);
    chk("ld_err", 32'(e), 32'd0);
    chk("ld_stalls", 32'(st), 32'd3);
    #1 chk("rdata_hold", rdat[0], 32'hDEADBEEF);

    op(0, 0, 1, 32'h100, 32'hA5A5A5A5, q, e, st);
    op(0, 1, 0, 32'h0, 32'h0, q, e, st);
    chk("wrap_rdata", q, 32'hA5A5A5A5);

    op(0, 0, 1, 32'h20, 32'hCAFEF00D, q, e, st);
    op(0, 1, 0, 32'h13, 32'h0, q, e, st);
    chk("mis_err", 32'(e), 32'd1);
    chk("mis_rdata", q, 32'h0);
    op(0, 1, 1, 32'h20, 32'h1, q, e, st);
    chk("both_err", 32'(e), 32'd1);
    chk("both_rdata", q, 32'h0);
    op(0, 1, 0, 32'h20, 32'h0, q, e, st);
    chk("both_nowrite", q, 32'hCAFEF00D);
    chk("both_after_err", 32'(e), 32'd0);

    op(1, 0, 1, 32'h8, 32'h0BADF00D, q, e, st);
    chk("l3_stalls", 32'(st), 32'd4);
    @(negedge clk);
    rd[1] = 0; wr[1] = 1; ad[1] = 32'h8; wd[1] = 32'h12345678;
    @(posedge clk);
    @(posedge clk);
    #1;
    rsts[1] = 1; wr[1] = 0;
    #1;
    chk("mid_rst_stall", 32'(stls[1]), 32'd0);
    chk("mid_rst_ack", 32'(acks[1]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rsts[1] = 0;
    nack = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      if (acks[1]) nack++;
    end
    chk("mid_rst_noack", 32'(nack), 32'd0);
    op(1, 1, 0, 32'h8, 32'h0, q, e, st);
    chk("mid_rst_mem", q, 32'h0BADF00D);

    op(2, 0, 1, 32'h0, 32'h11111111, q, e, st);
    chk("l1_stalls", 32'(st), 32'd2);
    op(2, 0, 1, 32'h4, 32'h22222222, q, e, st);
    @(negedge clk);
    rd[2] = 1; ad[2] = 32'h0;
    nack = 0; c1 = -1; c2 = -1; q1 = 'x; q2 = 'x;
    for (int c = 0; c < 15; c++) begin
      #1;
      if (acks[2]) begin
        nack++;
        if (nack == 1) begin c1 = c; q1 = rdat[2]; ad[2] = 32'h4; end
        else if (nack == 2) begin c2 = c; q2 = rdat[2]; rd[2] = 0; end
      end
      @(negedge clk);
    end
    chk("b2b_acks", 32'(nack), 32'd2);
    chk("b2b_spacing", 32'(c2 - c1), 32'd3);
    chk("b2b_first", q1, 32'h11111111);
    chk("b2b_second", q2, 32'h22222222);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
